// File: rtl/pixel_stream_writer_if.sv
// Bundles the serial video input, the write-window qualifier and the
// frame-memory write port of pixel_stream_writer.
//   master : the side that supplies serial bits, frame_start and wr_window
//            and observes the write port and status
//   slave  : pixel_stream_writer itself
// Ports carried:
//   bit_in, bit_valid        serial data bit and its qualifier
//   frame_start              single-cycle resync pulse
//   wr_window                frame memory may be written this cycle
//   wr_en, wr_addr, wr_data  frame-memory write port
//   fifo_level, overflow     queue occupancy and sticky drop flag
//   frame_done               pulse with the write of the last address
interface pixel_stream_writer_if #(
  parameter int ADDR_W = 10
);
  logic              bit_in;
  logic              bit_valid;
  logic              frame_start;
  logic              wr_window;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [5:0]        wr_data;
  logic [1:0]        fifo_level;
  logic              overflow;
  logic              frame_done;

  modport master (
    output bit_in, bit_valid, frame_start, wr_window,
    input  wr_en, wr_addr, wr_data, fifo_level, overflow, frame_done
  );

  modport slave (
    input  bit_in, bit_valid, frame_start, wr_window,
    output wr_en, wr_addr, wr_data, fifo_level, overflow, frame_done
  );
endinterface

// File: rtl/pixel_stream_writer.sv
// Deserialises a 1-bit video stream into RGB222 pixel words (MSB-first,
// first bit lands in bit 5) and writes them in raster order into the frame
// memory while the external write window is open. A 2-entry FIFO decouples
// bit arrival from window availability.
// Ports:
//   clk    system clock, all state on the rising edge
//   rst_n  asynchronous active-low reset
//   en     global enable; low freezes all state and silences strobes
//   bus    pixel_stream_writer_if.slave (stream in, write port out)
module pixel_stream_writer #(
  parameter int COLS   = 32,
  parameter int ROWS   = 24,
  parameter int ADDR_W = 10
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  pixel_stream_writer_if.slave        bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS * ROWS - 1);

  logic [5:0]        shift_q;
  logic [2:0]        bit_cnt;
  logic [5:0]        fifo_q [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        level;
  logic [ADDR_W-1:0] addr_cnt;
  logic              overflow_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [5:0]        wr_data_q;
  logic              frame_done_q;

  logic [5:0] word;
  logic       push;
  logic       pop;
  logic       push_ok;
  logic       drop;

  assign word = {shift_q[4:0], bus.bit_in};

  // frame_start overrides both the deserialiser and the write stage.
  assign push    = en && bus.bit_valid && (bit_cnt == 3'd5) && !bus.frame_start;
  assign pop     = en && bus.wr_window && (level != 2'd0) && !bus.frame_start;
  // When full, a simultaneous pop frees the slot the new word lands in.
  assign push_ok = push && ((level != 2'd2) || pop);
  assign drop    = push && (level == 2'd2) && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q      <= '0;
      bit_cnt      <= '0;
      fifo_q[0]    <= '0;
      fifo_q[1]    <= '0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      level        <= '0;
      addr_cnt     <= '0;
      overflow_q   <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
    end else if (!en) begin
      wr_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
    end else if (bus.frame_start) begin
      shift_q      <= '0;
      bit_cnt      <= '0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      level        <= '0;
      addr_cnt     <= '0;
      overflow_q   <= 1'b0;
      wr_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      if (bus.bit_valid) begin
        shift_q <= word;
        bit_cnt <= (bit_cnt == 3'd5) ? 3'd0 : bit_cnt + 3'd1;
      end

      if (push_ok) begin
        fifo_q[wr_ptr] <= word;
        wr_ptr         <= ~wr_ptr;
      end

      if (drop) overflow_q <= 1'b1;

      case ({push_ok, pop})
        2'b10:   level <= level + 2'd1;
        2'b01:   level <= level - 2'd1;
        default: level <= level;
      endcase

      if (pop) begin
        rd_ptr       <= ~rd_ptr;
        wr_en_q      <= 1'b1;
        wr_data_q    <= fifo_q[rd_ptr];
        wr_addr_q    <= addr_cnt;
        frame_done_q <= (addr_cnt == LAST_ADDR);
        addr_cnt     <= (addr_cnt == LAST_ADDR) ? '0 : addr_cnt + 1'b1;
      end else begin
        wr_en_q      <= 1'b0;
        frame_done_q <= 1'b0;
      end
    end
  end

  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.fifo_level = level;
  assign bus.overflow   = overflow_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_pixel_stream_writer.sv
// Directed bench for pixel_stream_writer: reset, raster wrap, window stall,
// overflow, resync and enable freeze, all with hand-computed expectations.
module tb_pixel_stream_writer;

  logic clk = 1'b0;
  logic rst_n;
  logic en;

  int n_checks = 0;
  int n_fail   = 0;

  pixel_stream_writer_if #(.ADDR_W(10)) bus ();

  pixel_stream_writer #(.COLS(32), .ROWS(24), .ADDR_W(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [5:0] w, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) begin
      bus.bit_in    = w[i];
      bus.bit_valid = 1'b1;
      tick();
    end
    bus.bit_valid = 1'b0;
  endtask

  task automatic send_word(input logic [5:0] w);
    send_bits(w, 5, 0);
  endtask

  task automatic check_write(input string tag, input int addr, input int data);
    check({tag, "_wr_en"}, int'(bus.wr_en), 1);
    check({tag, "_addr"},  int'(bus.wr_addr), addr);
    check({tag, "_data"},  int'(bus.wr_data), data);
  endtask

  initial begin
    rst_n           = 1'b0;
    en              = 1'b1;
    bus.bit_in      = 1'b0;
    bus.bit_valid   = 1'b0;
    bus.frame_start = 1'b0;
    bus.wr_window   = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_wr_en",      int'(bus.wr_en), 0);
    check("rst_wr_addr",    int'(bus.wr_addr), 0);
    check("rst_wr_data",    int'(bus.wr_data), 0);
    check("rst_level",      int'(bus.fifo_level), 0);
    check("rst_overflow",   int'(bus.overflow), 0);
    check("rst_frame_done", int'(bus.frame_done), 0);
    rst_n = 1'b1;
    tick();

    // First word: level 1 right after the 6th bit, write one edge later
    bus.wr_window = 1'b1;
    send_word(6'b101101);
    check("first_level",  int'(bus.fifo_level), 1);
    check("first_no_wr",  int'(bus.wr_en), 0);
    tick();
    check_write("first", 0, 6'h2D);
    check("first_level0", int'(bus.fifo_level), 0);
    tick();
    check("first_single", int'(bus.wr_en), 0);

    // Reset mid-stream with a queued pixel and a partial word
    bus.wr_window = 1'b0;
    send_word(6'h15);
    check("pre_rst_level", int'(bus.fifo_level), 1);
    send_bits(6'h3F, 5, 3);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_wr_data", int'(bus.wr_data), 0);
    check("mid_rst_level",   int'(bus.fifo_level), 0);
    check("mid_rst_wr_en",   int'(bus.wr_en), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.wr_window = 1'b1;
    tick();
    check("post_rst_no_wr", int'(bus.wr_en), 0);
    send_word(6'b101101);
    check("post_rst_level", int'(bus.fifo_level), 1);
    tick();
    check_write("post_rst", 0, 6'h2D);

    // Raster: resync then a full frame of 768 words plus one wrap
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    for (int k = 0; k < 768; k++) begin
      send_word(6'h3F);
      tick();
      check("raster_wr_en", int'(bus.wr_en), 1);
      check("raster_addr",  int'(bus.wr_addr), k);
      check("raster_done",  int'(bus.frame_done), (k == 767) ? 1 : 0);
    end
    check("raster_data", int'(bus.wr_data), 6'h3F);
    send_word(6'h3F);
    tick();
    check_write("wrap", 0, 6'h3F);
    check("wrap_done", int'(bus.frame_done), 0);

    // Window stall: two words held, then drained back to back
    bus.wr_window = 1'b0;
    send_word(6'h01);
    send_word(6'h02);
    check("stall_level", int'(bus.fifo_level), 2);
    check("stall_no_wr", int'(bus.wr_en), 0);
    bus.wr_window = 1'b1;
    tick();
    check_write("stall_w1", 1, 6'h01);
    check("stall_level1", int'(bus.fifo_level), 1);
    tick();
    check_write("stall_w2", 2, 6'h02);
    check("stall_level0", int'(bus.fifo_level), 0);
    tick();
    check("stall_idle", int'(bus.wr_en), 0);

    // Overflow: third word dropped, flag sticky
    bus.wr_window = 1'b0;
    send_word(6'h11);
    send_word(6'h22);
    check("ovf_before", int'(bus.overflow), 0);
    send_word(6'h33);
    check("ovf_set",   int'(bus.overflow), 1);
    check("ovf_level", int'(bus.fifo_level), 2);
    bus.wr_window = 1'b1;
    tick();
    check_write("ovf_w1", 3, 6'h11);
    tick();
    check_write("ovf_w2", 4, 6'h22);
    tick();
    check("ovf_no_third", int'(bus.wr_en), 0);
    check("ovf_sticky",   int'(bus.overflow), 1);

    // Resync with a queued word, a partial word, coincident bit and window
    bus.wr_window = 1'b0;
    send_word(6'h3C);
    send_bits(6'h3F, 5, 3);
    check("resync_pre_level", int'(bus.fifo_level), 1);
    bus.wr_window   = 1'b1;
    bus.bit_in      = 1'b1;
    bus.bit_valid   = 1'b1;
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    bus.bit_valid   = 1'b0;
    check("resync_ovf",   int'(bus.overflow), 0);
    check("resync_level", int'(bus.fifo_level), 0);
    check("resync_no_wr", int'(bus.wr_en), 0);
    send_word(6'h2A);
    tick();
    check_write("resync_w", 0, 6'h2A);

    // Enable freeze with a queued word and a partial word
    bus.wr_window = 1'b0;
    send_word(6'h05);
    send_bits(6'h33, 5, 3);
    bus.wr_window = 1'b1;
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.bit_valid = i[0];
      bus.bit_in    = ~i[1];
      tick();
      check("freeze_no_wr",  int'(bus.wr_en), 0);
      check("freeze_level",  int'(bus.fifo_level), 1);
      check("freeze_data",   int'(bus.wr_data), 6'h2A);
    end
    bus.bit_valid = 1'b0;
    en = 1'b1;
    tick();
    check_write("resume_w1", 1, 6'h05);
    send_bits(6'h33, 2, 0);
    check("resume_level", int'(bus.fifo_level), 1);
    tick();
    check_write("resume_w2", 2, 6'h33);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pixel_stream_writer.md
# pixel_stream_writer

Deserialises a 1-bit video data stream into 6-bit RGB222 pixel words and writes them, in raster order, into the frame memory that the VGA display path reads. Sits directly upstream of the video RAM: it produces the write port (enable, address, data) that fills it. Writes are gated by an external write window so the memory is only updated while the controller is not scanning active video. A 2-entry FIFO absorbs the phase difference between bit arrival and window availability.

## Interface
- COLS, 32, pixels per row of the frame buffer
- ROWS, 24, rows of the frame buffer
- ADDR_W, 10, write address width; COLS*ROWS must be ≤ 2^ADDR_W
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- en  input  1  global enable; low freezes all state
- bit_in  input  1  serial video data bit
- bit_valid  input  1  bit_in is sampled this cycle
- frame_start  input  1  single-cycle synchronous resync pulse
- wr_window  input  1  high when the frame memory may be written (blanking)
- wr_en  output  1  frame-memory write strobe, one cycle per pixel
- wr_addr  output  ADDR_W  pixel address, row*COLS+col
- wr_data  output  6  pixel {R[1:0],G[1:0],B[1:0]}
- fifo_level  output  2  pixel words waiting (0..2)
- overflow  output  1  sticky: a completed word was dropped
- frame_done  output  1  one-cycle pulse with the write of the last address

## Operation
- Reset (rst_n low, async): shift register, bit counter (0..5), FIFO, address counter cleared; all outputs 0.
- Deserialiser: on en & bit_valid, shift bit_in in MSB-first (first bit lands in wr_data[5]); bit counter increments 0→5. On the 6th bit the assembled word is pushed into the FIFO at that edge and the counter returns to 0.
- FIFO: depth 2, first-in first-out. fifo_level reflects contents after each edge.
- Write stage: each cycle where en & wr_window & FIFO non-empty, the head word is popped and registered onto wr_data, wr_addr takes the address counter, wr_en = 1. Otherwise wr_en = 0; wr_addr/wr_data hold last written values.
- Address counter: increments after each write; when the written address is COLS*ROWS-1 it wraps to 0 and frame_done = 1 in the same cycle as that wr_en.
- Push and pop on the same edge: allowed at any level, including full (level unchanged).
- Push while full with no pop: new word dropped, FIFO untouched, overflow set to 1. overflow clears only on reset or frame_start.
- frame_start (with en high): clears shift register, bit counter, FIFO, address counter, overflow; wr_en and frame_done 0 next cycle. Takes priority over a coincident bit_valid (bit discarded) and a coincident write (no write).
- en low: no shifting, pushing, popping or resync; wr_en and frame_done forced 0; other outputs hold.
- Reset asserted mid-word or mid-frame: partial word and queued pixels are lost; no write strobes until new data.

## Timing
- All outputs registered.
- Latency: 6th bit sampled at edge N → fifo_level=1 after N → wr_en=1 after edge N+1 if wr_window high in cycle N+1; no bypass path.
- Throughput: max one write per cycle; sustained input is at most one word per 6 cycles, so overflow only occurs when wr_window stays low for two completed words plus one more.
- wr_window low stalls writes indefinitely without loss up to 2 words.
- frame_done is never asserted without wr_en.

## Test plan
- Reset: hold rst_n low mid-stream → all outputs 0 immediately, fifo_level=0; after release, bits 101101 with window high → wr_en one cycle, wr_addr=0, wr_data=6'b101101 two edges after 6th bit.
- Raster/wrap: window high, stream 768 words of value 6'h3F → addresses 0..767 in order, frame_done only on address 767 write, next word writes address 0.
- Window stall: window low, send words 6'h01 then 6'h02 → fifo_level=2, no wr_en; raise window → writes 6'h01 then 6'h02 on consecutive cycles, level 2→1→0.
- Overflow: window low, send 3 words 6'h11, 6'h22, 6'h33 → overflow=1, level=2; open window → only 6'h11, 6'h22 written; overflow stays 1 until frame_start.
- Resync: after 3 bits of a word and address at 5, pulse frame_start coincident with bit_valid → overflow 0, level 0; next 6 bits form a fresh word written at address 0.
- Enable freeze: drop en for 10 cycles with bit_valid toggling and window high → no wr_en, state unchanged; resume → stream continues from the frozen bit count.
